// File: rtl/iomem_pkg.sv
// Shared constants and types for the PicoSoC iomem peripheral router.
// Region, index field, default error word, FSM encoding and slave map.
package iomem_pkg;

  localparam logic [7:0]  IOMEM_REGION = 8'h03;
  localparam int          IDX_HI       = 23;
  localparam int          IDX_LO       = 20;
  localparam int          OFS_W        = 20;
  localparam logic [31:0] ERR_WORD_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP
  } state_e;

  localparam int SLV_GPIO  = 0;
  localparam int SLV_TIMER = 1;

endpackage

// File: rtl/iomem_timeout.sv
// Clear/enable cycle counter that flags when LIMIT cycles have elapsed.
// Used by iomem_router only when IOMEM_ROUTER_TIMEOUT_EN is defined.
module iomem_timeout #(
  parameter logic [15:0] LIMIT = 16'd255
) (
  input  logic clk_bufg,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign expired_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iomem_router.sv
// Single-master to NSLAVE-slave router for the 0x03xx_xxxx iomem region.
// Define IOMEM_ROUTER_TIMEOUT_EN to compile in the slave timeout abort.
module iomem_router
  import iomem_pkg::*;
#(
  parameter int unsigned NSLAVE   = 4,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEF
) (
  input  logic                  clk_bufg,
  input  logic                  resetn,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic [31:0]           iomem_rdata,
  output logic [NSLAVE-1:0]     s_valid,
  input  logic [NSLAVE-1:0]     s_ready,
  output logic [3:0]            s_wstrb,
  output logic [OFS_W-1:0]      s_addr,
  output logic [31:0]           s_wdata,
  input  logic [32*NSLAVE-1:0]  s_rdata,
  output logic [7:0]            err_count,
  output logic                  err_pulse
);

  if (NSLAVE < 1 || NSLAVE > 16) begin : g_bad_nslave
    $error("iomem_router: NSLAVE must be 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("iomem_router: TIMEOUT must be 1..65535");
  end

  state_e          state_q, state_d;
  logic [3:0]      idx_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [3:0]      wstrb_q;
  logic [OFS_W-1:0] addr_q;
  logic [31:0]     wdata_q;
  logic [7:0]      cnt_q;

  logic [3:0]  idx;
  logic        hit;
  logic        idx_ok;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        tmo_expired;
  logic        err_set;

  assign idx    = iomem_addr[IDX_HI:IDX_LO];
  assign hit    = iomem_valid && (iomem_addr[31:24] == IOMEM_REGION);
  assign idx_ok = ({1'b0, idx} < 5'(NSLAVE));

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

`ifdef IOMEM_ROUTER_TIMEOUT_EN
  iomem_timeout #(
    .LIMIT(16'(TIMEOUT))
  ) u_tmo (
    .clk_bufg (clk_bufg),
    .resetn   (resetn),
    .clr_i    (state_q != ST_ACTIVE),
    .en_i     (state_q == ST_ACTIVE),
    .expired_o(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = idx_ok ? ST_ACTIVE : ST_RESP;
        end
      end
      ST_ACTIVE: begin
        if (sel_ready || tmo_expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_valid     = '0;
    iomem_ready = 1'b0;
    err_pulse   = 1'b0;
    unique case (state_q)
      ST_ACTIVE: begin
        for (int i = 0; i < NSLAVE; i++) begin
          s_valid[i] = (idx_q == 4'(i));
        end
      end
      ST_RESP: begin
        iomem_ready = 1'b1;
        err_pulse   = err_q;
      end
      default: ;
    endcase
  end

  // Slave ready beats a same-cycle timeout.
  assign err_set =
    ((state_q == ST_IDLE) && hit && !idx_ok) ||
    ((state_q == ST_ACTIVE) && !sel_ready && tmo_expired);

  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if ((state_q == ST_IDLE) && hit) begin
        idx_q   <= idx;
        wstrb_q <= iomem_wstrb;
        addr_q  <= iomem_addr[OFS_W-1:0];
        wdata_q <= iomem_wdata;
        err_q   <= !idx_ok;
        if (!idx_ok) begin
          rdata_q <= ERR_WORD;
        end
      end
      if (state_q == ST_ACTIVE) begin
        if (sel_ready) begin
          rdata_q <= sel_rdata;
          err_q   <= 1'b0;
        end else if (tmo_expired) begin
          rdata_q <= ERR_WORD;
          err_q   <= 1'b1;
        end
      end
      if (err_set && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign iomem_rdata = rdata_q;
  assign s_wstrb     = wstrb_q;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign err_count   = cnt_q;

endmodule
